shift_display_n: RTL and testbench

//  Parametrised successor of the 6-digit 4-bit switch-shift display block.

---
 rtl/shift_display_n_if.sv | 28 ++
 rtl/shift_display_n.sv | 124 ++++++++++++
 tb/tb_shift_display_n.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/shift_display_n_if.sv
// Bus bundle for shift_display_n: switch/key inputs from the board side,
// digit bus and status flags back from the display block.
interface shift_display_n_if #(
    parameter int DATA_W = 4,
    parameter int DIGITS = 6
);
    localparam int FILL_W = $clog2(DIGITS + 1);

    logic [DATA_W-1:0]        data;
    logic                     load;
    logic [1:0]               mode;
    logic                     clear;
    logic [DIGITS*DATA_W-1:0] out;
    logic [FILL_W-1:0]        fill;
    logic                     busy;
    logic                     ovr;
    logic [1:0]               ledr;

    modport master (
        output data, load, mode, clear,
        input  out, fill, busy, ovr, ledr
    );

    modport slave (
        input  data, load, mode, clear,
        output out, fill, busy, ovr, ledr
    );
endinterface

// File: rtl/shift_display_n.sv
// Switch-word shift/rotate display register: a load-key edge captures a word,
// shifts or rotates it through DIGITS stages, then publishes the digits.
module shift_display_n #(
    parameter int                DATA_W    = 4,
    parameter int                DIGITS    = 6,
    parameter int                BLANK_EN  = 0,
    parameter logic [DATA_W-1:0] BLANK_VAL = '1
) (
    input  logic               clock,
    input  logic               reset,
    shift_display_n_if.slave   bus
);
    localparam int FILL_W = $clog2(DIGITS + 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SHIFT  = 2'd1,
        S_UPDATE = 2'd2,
        S_SPARE  = 2'd3
    } state_t;

    state_t                        r_state;
    state_t                        w_next;
    logic                          r_load_q;
    logic [DATA_W-1:0]             r_mem;
    logic [1:0]                    r_mode_q;
    logic [DIGITS-1:0][DATA_W-1:0] r_regs;
    logic [DIGITS-1:0][DATA_W-1:0] w_shifted;
    logic [DIGITS-1:0][DATA_W-1:0] w_view;
    logic [DIGITS*DATA_W-1:0]      r_out;
    logic [FILL_W-1:0]             r_fill;
    logic                          r_ovr;
    logic                          w_edge;
    logic                          w_push;

    assign w_edge = bus.load & ~r_load_q;
    assign w_push = ~r_mode_q[1];

    always_ff @(posedge clock) begin
        if (!reset) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    // NOTE: every signal written in always_comb gets a default first so no latch is inferred.
    always_comb begin
        w_next = r_state;
        if (bus.clear) begin
            w_next = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE:   if (w_edge) w_next = S_SHIFT;
                S_SHIFT:  w_next = S_UPDATE;
                S_UPDATE: w_next = S_IDLE;
                default:  w_next = S_IDLE;
            endcase
        end
    end

    // Element 0 sits at the LSB end of the packed array, so "up" is a left concat.
    always_comb begin
        w_shifted = r_regs;
        case (r_mode_q)
            2'b00: w_shifted = {r_regs[DIGITS-2:0], r_mem};
            2'b01: w_shifted = {r_mem, r_regs[DIGITS-1:1]};
            2'b10: w_shifted = {r_regs[DIGITS-2:0], r_regs[DIGITS-1]};
            2'b11: w_shifted = {r_regs[0], r_regs[DIGITS-1:1]};
            default: w_shifted = r_regs;
        endcase
    end

    always_comb begin
        w_view = r_regs;
        for (int i = 0; i < DIGITS; i++) begin
            if (BLANK_EN != 0 && r_mode_q == 2'b00 && i >= int'(r_fill))
                w_view[i] = BLANK_VAL;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only; the digit
    // stages are plain flops, so zeroing them on reset and clear is cheap.
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_load_q <= 1'b0;
            r_mem    <= '0;
            r_mode_q <= 2'b00;
            r_regs   <= '0;
            r_out    <= '0;
            r_fill   <= '0;
            r_ovr    <= 1'b0;
        end else begin
            r_load_q <= bus.load;
            if (bus.clear) begin
                r_regs <= '0;
                r_out  <= '0;
                r_fill <= '0;
                r_ovr  <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (w_edge) begin
                            r_mem    <= bus.data;
                            r_mode_q <= bus.mode;
                        end
                    end
                    S_SHIFT: begin
                        r_regs <= w_shifted;
                        if (w_push && r_fill != FILL_W'(DIGITS))
                            r_fill <= r_fill + FILL_W'(1);
                    end
                    S_UPDATE: r_out <= w_view;
                    default: ;
                endcase
                if (w_edge && r_state != S_IDLE)
                    r_ovr <= 1'b1;
            end
        end
    end

    assign bus.out  = r_out;
    assign bus.fill = r_fill;
    assign bus.busy = (r_state != S_IDLE);
    assign bus.ovr  = r_ovr;
    assign bus.ledr = r_state;
endmodule

// File: tb/tb_shift_display_n.sv
// Bench for shift_display_n: a plain and a blanking instance share stimulus and
// are compared against a queue-based digit model.
module tb_shift_display_n;
    logic clock;
    logic reset;

    shift_display_n_if #(.DATA_W(4), .DIGITS(6)) if0 ();
    shift_display_n_if #(.DATA_W(4), .DIGITS(6)) if1 ();

    shift_display_n #(.DATA_W(4), .DIGITS(6), .BLANK_EN(0), .BLANK_VAL(4'hF)) dut0 (
        .clock (clock),
        .reset (reset),
        .bus   (if0.slave)
    );

    shift_display_n #(.DATA_W(4), .DIGITS(6), .BLANK_EN(1), .BLANK_VAL(4'hF)) dut1 (
        .clock (clock),
        .reset (reset),
        .bus   (if1.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_pass   = 0;
    int n_checks = 0;

    logic [3:0]  q[$];
    int          m_fill;
    logic        m_ovr;
    logic [23:0] m_out0;
    logic [23:0] m_out1;

    task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(logic ld, logic [3:0] d, logic [1:0] m, logic clr);
        if0.load = ld; if0.data = d; if0.mode = m; if0.clear = clr;
        if1.load = ld; if1.data = d; if1.mode = m; if1.clear = clr;
    endtask

    task automatic model_clear();
        q = '{4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0};
        m_fill = 0;
        m_ovr  = 1'b0;
        m_out0 = '0;
        m_out1 = '0;
    endtask

    // Digit i of the display is q[i]; pushes enter at one end and fall off the other.
    task automatic model_op(logic [3:0] d, logic [1:0] m);
        logic [3:0] t;
        case (m)
            2'b00: begin q.push_front(d); t = q.pop_back(); end
            2'b01: begin q.push_back(d);  t = q.pop_front(); end
            2'b10: begin t = q.pop_back();  q.push_front(t); end
            default: begin t = q.pop_front(); q.push_back(t); end
        endcase
        if (m[1] == 1'b0 && m_fill < 6) m_fill++;
        for (int i = 0; i < 6; i++) begin
            m_out0[i*4 +: 4] = q[i];
            m_out1[i*4 +: 4] = (m == 2'b00 && i >= m_fill) ? 4'hF : q[i];
        end
    endtask

    task automatic check_state(string tag);
        check({tag, ".out0"},  64'(if0.out),  64'(m_out0));
        check({tag, ".out1"},  64'(if1.out),  64'(m_out1));
        check({tag, ".fill0"}, 64'(if0.fill), 64'(m_fill));
        check({tag, ".fill1"}, 64'(if1.fill), 64'(m_fill));
        check({tag, ".ovr0"},  64'(if0.ovr),  64'(m_ovr));
        check({tag, ".ovr1"},  64'(if1.ovr),  64'(m_ovr));
        check({tag, ".busy"},  64'(if0.busy), 64'(0));
        check({tag, ".ledr"},  64'(if0.ledr), 64'(0));
    endtask

    // One complete op: busy for exactly two cycles, out moves on the third edge.
    task automatic do_op(string tag, logic [3:0] d, logic [1:0] m);
        drive(1'b1, d, m, 1'b0);
        tick();
        check({tag, ".busyN"}, 64'(if0.busy & if1.busy), 64'(1));
        check({tag, ".ledrN"}, 64'(if0.ledr), 64'(1));
        drive(1'b0, 4'($urandom), ~m, 1'b0);
        tick();
        check({tag, ".ledrN1"}, 64'(if1.ledr), 64'(2));
        check({tag, ".outN1"},  64'(if0.out), 64'(m_out0));
        model_op(d, m);
        tick();
        check_state(tag);
    endtask

    task automatic do_clear(string tag);
        drive(1'b0, 4'h0, 2'b00, 1'b1);
        tick();
        model_clear();
        check_state(tag);
        drive(1'b0, 4'h0, 2'b00, 1'b0);
    endtask

    initial begin
        reset = 1'b0;
        drive(1'b0, 4'h0, 2'b00, 1'b0);
        model_clear();
        tick();
        tick();
        check_state("reset");
        reset = 1'b1;
        tick();

        // Seven pushes up: oldest value falls off, fill saturates at six.
        for (int k = 1; k <= 7; k++) do_op("push_up", 4'(k), 2'b00);
        check("t1_const", 64'(if0.out), 64'h234567);

        do_op("rot_up", 4'hE, 2'b10);
        check("t3_const", 64'(if0.out), 64'h345672);

        // Holding the key down must give exactly one op.
        drive(1'b1, 4'h9, 2'b11, 1'b0);
        tick(); tick(); tick();
        model_op(4'h9, 2'b11);
        check_state("hold_a");
        tick(); tick(); tick();
        check_state("hold_b");
        drive(1'b0, 4'h0, 2'b00, 1'b0);
        tick();

        do_clear("clr1");
        do_op("push_dn_a", 4'hA, 2'b01);
        do_op("push_dn_b", 4'hB, 2'b01);
        check("t2_const", 64'(if1.out), 64'hBA0000);

        do_clear("clr2");
        do_op("blank", 4'h3, 2'b00);
        check("t6_const", 64'(if1.out), 64'hFFFFF3);

        // Second edge lands while the first op is still in UPDATE.
        drive(1'b1, 4'h9, 2'b00, 1'b0);
        tick();
        drive(1'b0, 4'h0, 2'b00, 1'b0);
        tick();
        drive(1'b1, 4'h5, 2'b00, 1'b0);
        tick();
        model_op(4'h9, 2'b00);
        m_ovr = 1'b1;
        check_state("ovr_a");
        drive(1'b0, 4'h0, 2'b00, 1'b0);
        tick();
        check_state("ovr_b");

        drive(1'b1, 4'h7, 2'b00, 1'b0);
        tick();
        drive(1'b0, 4'h0, 2'b00, 1'b1);
        tick();
        model_clear();
        check_state("clr_shift");
        drive(1'b0, 4'h0, 2'b00, 1'b0);
        tick();

        // A load edge coincident with clear is dropped, and held load does not retrigger.
        do_op("pre", 4'h4, 2'b00);
        drive(1'b1, 4'h6, 2'b00, 1'b1);
        tick();
        model_clear();
        drive(1'b1, 4'h6, 2'b00, 1'b0);
        tick();
        tick();
        check_state("clr_edge");
        drive(1'b0, 4'h0, 2'b00, 1'b0);
        tick();

        do_op("pre2", 4'h8, 2'b01);
        drive(1'b1, 4'h2, 2'b00, 1'b0);
        tick();
        reset = 1'b0;
        drive(1'b0, 4'h0, 2'b00, 1'b0);
        tick();
        reset = 1'b1;
        model_clear();
        check_state("rst_mid");
        tick();

        for (int k = 0; k < 40; k++) begin
            if ($urandom_range(7) == 0) do_clear("rnd_clr");
            else do_op("rnd", 4'($urandom), 2'($urandom));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
